// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM, run prescaler, per-digit edit strobes and edit blink
module stopwatch_ctrl #(
    parameter int unsigned PULSE_MAX = 999999,
    parameter int unsigned BLINK_MAX = 24999999
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic       start_stop_pressed_i,
    input  logic       set_pressed_i,
    input  logic       change_pressed_i,
    output logic       run_o,
    output logic       tick_o,
    output logic [3:0] inc_digit_o,
    output logic [3:0] blank_o,
    output logic [2:0] state_o
);

    localparam int PW = (PULSE_MAX < 1) ? 1 : $clog2(PULSE_MAX + 1);
    localparam int BW = (BLINK_MAX < 1) ? 1 : $clog2(BLINK_MAX + 1);
    localparam logic [PW-1:0] PULSE_TC = PW'(PULSE_MAX);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT0 = 3'd1,
        ST_EDIT1 = 3'd2,
        ST_EDIT2 = 3'd3,
        ST_EDIT3 = 3'd4,
        ST_RUN   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic            run_q, run_d;
    logic            tick_q, tick_d;
    logic [3:0]      inc_q, inc_d;
    logic [3:0]      blank_q, blank_d;
    logic [1:0]      digit_q, digit_d;
    logic            edit_d;

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            run_q       <= 1'b0;
            tick_q      <= 1'b0;
            inc_q       <= '0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            run_q       <= run_d;
            tick_q      <= tick_d;
            inc_q       <= inc_d;
            blank_q     <= blank_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tick_d      = 1'b0;
        inc_d       = '0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = '0;
        digit_q     = 2'(state_q - ST_EDIT0);

        // A stop pulse freezes the prescaler, so a wrap in that cycle is deferred to the resume.
        case (state_q)
            ST_IDLE: begin
                if (start_stop_pressed_i) begin
                    state_d = ST_RUN;
                end else if (set_pressed_i) begin
                    state_d = ST_EDIT0;
                end
            end
            ST_RUN: begin
                if (start_stop_pressed_i) begin
                    state_d = ST_IDLE;
                end else if (presc_q == PULSE_TC) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_EDIT0, ST_EDIT1, ST_EDIT2, ST_EDIT3: begin
                if (set_pressed_i) begin
                    state_d = (state_q == ST_EDIT3) ? ST_IDLE : state_t'(state_q + 3'd1);
                end else if (change_pressed_i) begin
                    inc_d = 4'b0001 << digit_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        edit_d  = (state_d == ST_EDIT0) || (state_d == ST_EDIT1) ||
                  (state_d == ST_EDIT2) || (state_d == ST_EDIT3);
        digit_d = 2'(state_d - ST_EDIT0);
        run_d   = (state_d == ST_RUN);

        // Restarting the blink on entry or change keeps the edited digit visible right away.
        if (!edit_d || (state_d != state_q) || (inc_d != 4'b0000)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        if (edit_d && phase_d) begin
            blank_d = 4'b0001 << digit_d;
        end
    end

    assign run_o       = run_q;
    assign tick_o      = tick_q;
    assign inc_digit_o = inc_q;
    assign blank_o     = blank_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl against a behavioural mode model
module tb_stopwatch_ctrl;

    localparam int P = 3;
    localparam int B = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss = 1'b0, st = 1'b0, ch = 1'b0;
    logic       run, tick;
    logic [3:0] inc, blank;
    logic [2:0] state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.PULSE_MAX(P), .BLINK_MAX(B)) dut (
        .clk100_i             (clk),
        .rst_i                (rst),
        .start_stop_pressed_i (ss),
        .set_pressed_i        (st),
        .change_pressed_i     (ch),
        .run_o                (run),
        .tick_o               (tick),
        .inc_digit_o          (inc),
        .blank_o              (blank),
        .state_o              (state)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       run;
        logic       tick;
        logic [3:0] inc;
        logic [3:0] blank;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // mode: 0 idle, 1..4 editing digit mode-1, 5 running
    int mode = 0;
    int run_clocks = 0;
    int edit_age = 0;

    function automatic obs_t model_step(input bit a, input bit b, input bit c);
        obs_t e;
        int   nm;
        bit   restart;
        e  = '0;
        nm = mode;
        if (mode == 0) begin
            if (a) nm = 5;
            else if (b) nm = 1;
        end else if (mode == 5) begin
            if (a) nm = 0;
            else begin
                run_clocks++;
                e.tick = (run_clocks % (P + 1) == 0);
            end
        end else begin
            if (b) nm = (mode == 4) ? 0 : mode + 1;
            else if (c) e.inc = 4'(1 << (mode - 1));
        end
        restart = (nm != mode) || (e.inc != 4'b0000);
        mode = nm;
        if (mode >= 1 && mode <= 4) begin
            edit_age = restart ? 0 : edit_age + 1;
            if ((edit_age / (B + 1)) % 2 == 1) e.blank = 4'(1 << (mode - 1));
        end else begin
            edit_age = 0;
        end
        e.run   = (mode == 5);
        e.state = 3'(mode);
        return e;
    endfunction

    task automatic cycle(input bit a, input bit b, input bit c);
        ss = a; st = b; ch = c;
        exp_q.push_back(model_step(a, b, c));
        @(negedge clk);
        ss = 1'b0; st = 1'b0; ch = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ss = 1'b0; st = 1'b0; ch = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, run, tick, inc, blank} != 13'd0) begin
            errors++;
            $display("FAIL async_reset got state=%0d run=%b tick=%b inc=%b blank=%b want all 0",
                     state, run, tick, inc, blank);
        end
        mode = 0; run_clocks = 0; edit_age = 0;
        exp_q.push_back('0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        obs_t e;
        obs_t got;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state, run, tick, inc, blank};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got state=%0d run=%b tick=%b inc=%b blank=%b want state=%0d run=%b tick=%b inc=%b blank=%b",
                             cyc, got.state, got.run, got.tick, got.inc, got.blank,
                             e.state, e.run, e.tick, e.inc, e.blank);
                end
            end
        end
    end

    initial begin : stimulus
        @(negedge clk);
        do_reset();

        // run, tick cadence, stop
        cycle(1, 0, 0); idle(12); cycle(1, 0, 0); idle(6);
        // pause with prescaler at 2, resume
        cycle(1, 0, 0); idle(2); cycle(1, 0, 0); idle(50); cycle(1, 0, 0); idle(6); cycle(1, 0, 0);
        // stop exactly at terminal count, resume ticks at once
        cycle(1, 0, 0); idle(2); cycle(1, 0, 0); idle(3); cycle(1, 0, 0); idle(5); cycle(1, 0, 0);

        // edit walk
        cycle(0, 1, 0);
        repeat (3) begin cycle(0, 0, 1); idle(1); end
        cycle(0, 1, 0); cycle(0, 0, 1);
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); idle(2);

        // blink in EDIT2, change restarts phase
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); idle(20);
        cycle(0, 0, 1); idle(14); cycle(0, 1, 0); cycle(0, 1, 0); idle(5);

        // coincident pulses
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 0); idle(1);
        cycle(1, 1, 0); idle(2); cycle(1, 0, 0);
        cycle(0, 1, 0); cycle(1, 0, 1); cycle(1, 1, 1); idle(1);
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); idle(1);

        // reset mid-RUN, then mid-EDIT3 with blank high
        cycle(1, 0, 0); idle(2); do_reset();
        cycle(1, 0, 0); idle(9); cycle(1, 0, 0);
        cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); idle(8); do_reset();
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
